demux_deserializer: RTL
=======================

// Module: demux_deserializer
// PURPOSE
//  Receive end of the 8:1 select-mux serial path. Takes one bit per accepted
//  beat and steers it (1:8 demux) into an output word register. Slot order
//  matches the mux: slot s=0 writes bit WIDTH-1, and slot s=WIDTH-1 writes bit 0.
//  After WIDTH beats it presents the full word on a valid/ready handshake.
// PARAMETERS
//  WIDTH  8  word width, i.e. the number of serial beats per word
//  SEL_W  3  slot counter width; must satisfy 2**SEL_W >= WIDTH
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  clear       in   1        synchronous flush: abort the current word
//  din         in   1        serial data bit
//  din_valid   in   1        din is valid this cycle
//  din_ready   out  1        block accepts din this cycle
//  dout        out  WIDTH    assembled word
//  dout_valid  out  1        dout holds a complete word
//  dout_ready  in   1        consumer takes dout this cycle
//  sel         out  SEL_W    slot index of the next accepted bit
//  par_err     out  1        parity error flag; qualified by dout_valid
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low.
//  - Reset values:
//    - state=COLLECT, sel=0, dout=0, dout_valid=0, par_err=0.
//  - Accept event: din_valid && din_ready.
//  - din_ready = (state==COLLECT) || (state==PARITY) || (state==HOLD && dout_ready).
//  - COLLECT, on accept:
//    - dout[WIDTH-1-sel] <= din; other bits hold.
//    - If sel==WIDTH-1: sel <= 0, go to HOLD (or to PARITY, see CONFIGURATION).
//    - Otherwise sel <= sel+1.
//  - HOLD:
//    - dout_valid=1. dout and par_err are stable until the handshake.
//    - dout_valid && dout_ready with no accept: dout_valid <= 0, go to COLLECT.
//    - Handshake and accept in the same cycle: the word is consumed and the
//      incoming bit is written to dout[WIDTH-1] of the next word.
//      Then sel <= 1, go to COLLECT. Bits not yet written keep stale values.
//  - dout_valid rises one cycle after the final data beat (or the parity beat)
//    is accepted. Latency from the first beat is WIDTH cycles at full rate,
//    WIDTH+1 with parity. One beat per cycle is sustainable, no bubble.
//  - din_valid=0 mid-word: sel and the partial word hold indefinitely. No timeout.
//  - The counter never wraps past WIDTH-1. Arithmetic is unsigned, mod 2**SEL_W.
//  - clear has priority over every other event:
//    - Next edge: state=COLLECT, sel=0, dout_valid=0, par_err=0.
//    - dout is not modified. A beat offered in the same cycle is dropped.
//  - Reset asserted mid-word: all state is lost immediately (asynchronous).
//  - The producer must hold din/din_valid stable while din_ready=0.
// CONFIGURATION
//  DEMUX_PARITY_EN defined:
//    - After WIDTH data beats, go to PARITY and accept one more beat (even parity).
//    - On that accept: par_err <= (^dout) ^ din, go to HOLD.
//    - sel stays at 0 during PARITY.
//  DEMUX_PARITY_EN undefined:
//    - No PARITY state. The final data beat goes straight to HOLD.
//    - par_err is tied to 0. The port list is identical in both builds.
// TESTING
//  1. Reset, then stream 1,0,1,1,0,0,1,0 with din_valid=1 and dout_ready=0.
//     -> dout=8'hB2, dout_valid=1 on the cycle after beat 8; din_ready=0.
//  2. Back-to-back words 8'hB2 then 8'h5A, dout_ready=1 and din_valid=1 throughout.
//     -> Two dout_valid pulses exactly 8 cycles apart; no beat lost.
//  3. Feed 3 beats (1,1,1), drop din_valid for 5 cycles, resume with 0,0,0,0,1.
//     -> sel holds at 3 during the gap; final dout=8'hE1.
//  4. Pulse clear after 4 beats, then feed 8 beats of 8'h0F.
//     -> dout_valid=0 after clear, sel=0; next dout=8'h0F.
//  5. Assert rst_n=0 mid-cycle, between edges, after 5 beats.
//     -> sel=0, dout=0 and dout_valid=0 immediately, without waiting for a clock edge.
//  6. DEMUX_PARITY_EN: word 8'hB2 (four 1s) with parity bit 1.
//     -> par_err=1; with parity bit 0, par_err=0; dout_valid appears after 9 beats.

Source files
------------

// File: rtl/demux_deserializer.sv
// Serial-to-parallel 1:8 demux with valid/ready word output.
// Optional even-parity beat after each word when DEMUX_PARITY_EN is defined.
module demux_deserializer #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [SEL_W-1:0] sel,
  output logic             par_err
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               accept;
`ifdef DEMUX_PARITY_EN
  logic               par_err_q, par_err_d;
`endif

  assign din_ready  = (state_q == COLLECT) || (state_q == PARITY) ||
                      ((state_q == HOLD) && dout_ready);
  assign accept     = din_valid && din_ready;
  assign dout_valid = (state_q == HOLD);
  assign dout       = dout_q;
  assign sel        = sel_q;
`ifdef DEMUX_PARITY_EN
  assign par_err    = par_err_q;
`else
  assign par_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
`ifdef DEMUX_PARITY_EN
    par_err_d = par_err_q;
`endif
    if (clear) begin
      // Flush wins over any beat offered this cycle; dout is left as-is.
      state_d = COLLECT;
      sel_d   = '0;
`ifdef DEMUX_PARITY_EN
      par_err_d = 1'b0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              if (sel_q == SEL_W'(WIDTH - 1 - i)) dout_d[i] = din;
            end
            if (sel_q == SEL_W'(WIDTH - 1)) begin
              sel_d = '0;
`ifdef DEMUX_PARITY_EN
              state_d = PARITY;
`else
              state_d = HOLD;
`endif
            end else begin
              sel_d = sel_q + SEL_W'(1);
            end
          end
        end
`ifdef DEMUX_PARITY_EN
        PARITY: begin
          if (accept) begin
            par_err_d = (^dout_q) ^ din;
            state_d   = HOLD;
          end
        end
`endif
        HOLD: begin
          if (dout_ready) begin
            state_d = COLLECT;
            // Consume and start the next word in the same cycle: slot 0 lands now.
            if (accept) begin
              dout_d[WIDTH-1] = din;
              sel_d           = SEL_W'(1);
            end
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      sel_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
    end
  end

`ifdef DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end
`endif

endmodule
